// File: rtl/instr_encoder.sv
// RV32I instruction encoder (ADD/AND/ADDI/LW/SW/BEQ) with word-address tagging; optional macro IMM_RANGE_CHECK_EN.
// Latency: 1 cycle from request accept to registered output word.
// Backpressure: single output register; in_ready drops while a held word is stalled or restart is asserted.
module instr_encoder #(
  parameter int                ADDR_W    = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        accept;
  logic        xfer;

`ifdef IMM_RANGE_CHECK_EN
  // 12-bit signed fit: bit 12 must merely sign-extend bit 11.
  logic imm12_ok;
  // Branch offsets must be even; the 13-bit range already caps at 4095, which is odd.
  logic immb_ok;
  assign imm12_ok = (in_imm[12] == in_imm[11]);
  assign immb_ok  = ~in_imm[0];
`endif

  // restart blocks acceptance outright; otherwise accept when the output slot is free or draining.
  assign in_ready = !restart && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready && !restart;

  // Field packing per instruction format; illegal opcodes (and bad immediates when checked) become NOP.
  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b0;
    case (in_op)
      OP_ADD:  enc_instr = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
      OP_AND:  enc_instr = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_R};
      OP_ADDI: enc_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_OPIMM};
      OP_LW:   enc_instr = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
      OP_SW:   enc_instr = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
      OP_BEQ:  enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                            in_imm[4:1], in_imm[11], OPC_BRANCH};
      default: begin
        enc_instr = NOP;
        enc_err   = 1'b1;
      end
    endcase
`ifdef IMM_RANGE_CHECK_EN
    if (((in_op == OP_ADDI) || (in_op == OP_LW) || (in_op == OP_SW)) && !imm12_ok) begin
      enc_instr = NOP;
      enc_err   = 1'b1;
    end
    if ((in_op == OP_BEQ) && !immb_ok) begin
      enc_instr = NOP;
      enc_err   = 1'b1;
    end
`endif
  end

  // Output register and address counter; restart flushes and rewinds ahead of any handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= BASE_ADDR;
    end else if (restart) begin
      out_valid <= 1'b0;
      out_addr  <= BASE_ADDR;
    end else begin
      if (xfer) begin
        out_addr <= out_addr + ADDR_W'(1);
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= enc_instr;
        out_err   <= enc_err;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Saturating count of error words actually handed to the consumer; survives restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (xfer && out_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal checks plus randomized traffic against a behavioural model.
// Two DUT copies share stimulus: ADDR_W=9 and ADDR_W=2 (address wrap).
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, out_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [8:0]  out_addr;
  logic [7:0]  err_count;

  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] out_instr2;
  logic [1:0]  out_addr2;
  logic [7:0]  err_count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(9)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_addr(out_addr2), .out_err(out_err2), .err_count(err_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from the instruction-format rules with plain integer arithmetic.
  function automatic logic [32:0] model_enc(int op, int rd, int rs1, int rs2, int imm);
    int w;
    bit bad;
    w = 0;
    bad = 0;
    case (op)
      0: w = 'h33 + (rd << 7) + (rs1 << 15) + (rs2 << 20);
      1: w = 'h33 + (rd << 7) + (7 << 12) + (rs1 << 15) + (rs2 << 20);
      2: w = 'h13 + (rd << 7) + (rs1 << 15) + ((imm & 'hfff) << 20);
      3: w = 'h03 + (rd << 7) + (2 << 12) + (rs1 << 15) + ((imm & 'hfff) << 20);
      4: w = 'h23 + ((imm & 31) << 7) + (2 << 12) + (rs1 << 15) + (rs2 << 20)
             + (((imm >> 5) & 'h7f) << 25);
      5: w = 'h63 + (((imm >> 11) & 1) << 7) + (((imm >> 1) & 15) << 8) + (rs1 << 15)
             + (rs2 << 20) + (((imm >> 5) & 63) << 25) + (((imm >> 12) & 1) << 31);
      default: bad = 1;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    if (op >= 2 && op <= 4 && (imm < -2048 || imm > 2047)) bad = 1;
    if (op == 5 && (imm < -4096 || imm > 4094 || (imm & 1) != 0)) bad = 1;
`endif
    if (bad) w = 'h13;
    return {bad, 32'(w)};
  endfunction

  // Model state: what the outputs must show after the most recent edge.
  bit          m_valid = 0;
  logic [31:0] m_instr = 0;
  bit          m_err = 0;
  int          m_addr = 0;
  int          m_ecnt = 0;
  bit          m_rdy;
  logic [32:0] m_enc;

  typedef struct {
    logic [31:0] instr;
    int          addr;
    int          addr2;
    logic        err;
  } xfer_t;
  xfer_t log_q[$];

  // Compare DUT against the model every cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      m_valid = 0; m_instr = 0; m_err = 0; m_addr = 0; m_ecnt = 0;
    end
    m_rdy = !restart && (!m_valid || out_ready);
    check("in_ready", in_ready, m_rdy);
    check("out_valid", out_valid, m_valid);
    check("out_addr", out_addr, m_addr % 512);
    check("err_count", err_count, m_ecnt);
    check("out_valid_w2", out_valid2, m_valid);
    check("out_addr_w2", out_addr2, m_addr % 4);
    if (m_valid) begin
      check("out_instr", out_instr, m_instr);
      check("out_err", out_err, m_err);
    end
    if (!reset) begin
      if (out_valid && out_ready && !restart)
        log_q.push_back('{instr: out_instr, addr: out_addr, addr2: out_addr2, err: out_err});
      if (restart) begin
        m_valid = 0;
        m_addr = 0;
      end else begin
        if (m_valid && out_ready) begin
          m_addr = (m_addr + 1) % 512;
          if (m_err && m_ecnt < 255) m_ecnt++;
          m_valid = 0;
        end
        if (in_valid && m_rdy) begin
          m_enc = model_enc(in_op, in_rd, in_rs1, in_rs2, int'($signed(in_imm)));
          m_valid = 1;
          m_instr = m_enc[31:0];
          m_err = m_enc[32];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until it has been taken by an edge.
  task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm);
    int n;
    in_valid = 1'b1;
    in_op = 3'(op);
    in_rd = 5'(rd);
    in_rs1 = 5'(rs1);
    in_rs2 = 5'(rs2);
    in_imm = 13'(imm);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles, required 1", n);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  int imm_pool[11] = '{-4096, -4095, -2049, -2048, -1, 0, 1, 2047, 2048, 4094, 4095};
  int n0;

  initial begin
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 1);

    // Single ADD, one cycle after accept
    step();
    out_ready = 1'b1;
    send(0, 3, 1, 2, 0);
    @(negedge clk);
    check("add_valid", out_valid, 1);
    check("add_instr", out_instr, 32'h002081B3);
    check("add_addr", out_addr, 0);
    check("add_err", out_err, 0);
    step();
    pulse_restart();
    log_q.delete();

    // LW, SW, BEQ back-to-back
    send(3, 5, 2, 0, 8);
    send(4, 0, 2, 5, 12);
    send(5, 0, 1, 2, -4);
    repeat (3) step();
    check("stream_count", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      check("lw_instr", log_q[0].instr, 32'h00812283);
      check("lw_addr", log_q[0].addr, 0);
      check("sw_instr", log_q[1].instr, 32'h00512623);
      check("sw_addr", log_q[1].addr, 1);
      check("beq_instr", log_q[2].instr, 32'hFE208EE3);
      check("beq_addr", log_q[2].addr, 2);
    end

    // Backpressure: word held three cycles, transferred once
    out_ready = 1'b0;
    n0 = log_q.size();
    send(2, 7, 4, 0, 100);
    repeat (3) begin
      @(negedge clk);
      check("bp_instr", out_instr, 32'h06420393);
      check("bp_addr", out_addr, 3);
      check("bp_in_ready", in_ready, 0);
    end
    step();
    out_ready = 1'b1;
    repeat (3) step();
    check("bp_once", log_q.size(), n0 + 1);
    if (log_q.size() == n0 + 1) check("bp_xfer_instr", log_q[n0].instr, 32'h06420393);

    // Illegal opcode and out-of-range ADDI immediate
    n0 = log_q.size();
    send(7, 1, 1, 1, 0);
    send(2, 0, 0, 0, 2048);
    repeat (3) step();
    check("err_xfers", log_q.size(), n0 + 2);
    if (log_q.size() >= n0 + 2) begin
      check("illegal_instr", log_q[n0].instr, 32'h00000013);
      check("illegal_err", log_q[n0].err, 1);
`ifdef IMM_RANGE_CHECK_EN
      check("addi2048_instr", log_q[n0+1].instr, 32'h00000013);
      check("addi2048_err", log_q[n0+1].err, 1);
`else
      check("addi2048_instr", log_q[n0+1].instr, 32'h80000013);
      check("addi2048_err", log_q[n0+1].err, 0);
`endif
    end
    @(negedge clk);
`ifdef IMM_RANGE_CHECK_EN
    check("err_count_2", err_count, 2);
`else
    check("err_count_1", err_count, 1);
`endif

    // Address wrap on the 2-bit counter
    step();
    pulse_restart();
    log_q.delete();
    for (int i = 0; i < 5; i++) send(0, i, i + 1, i + 2, 0);
    repeat (3) step();
    check("wrap_count", log_q.size(), 5);
    if (log_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("wrap_addr2", log_q[i].addr2, i % 4);
        check("wrap_addr9", log_q[i].addr, i);
      end
    end

    // restart dominates a pending word plus a simultaneous request
    out_ready = 1'b0;
    send(0, 1, 2, 3, 0);
    n0 = log_q.size();
    in_valid = 1'b1; in_op = 3'd2; in_rd = 5'd2; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 13'd5;
    restart = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rs_in_ready", in_ready, 0);
    step();
    restart = 1'b0;
    @(negedge clk);
    check("rs_out_valid", out_valid, 0);
    check("rs_out_addr", out_addr, 0);
    check("rs_in_ready_after", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("rs_accept_valid", out_valid, 1);
    check("rs_accept_instr", out_instr, 32'h00500113);
    check("rs_accept_addr", out_addr, 0);
    check("rs_no_xfer", log_q.size(), n0);

    // Randomized traffic against the model
    step();
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 1499) == 0);
      restart  = ($urandom_range(0, 29) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_op  = 3'($urandom_range(0, 7));
      in_rd  = 5'($urandom);
      in_rs1 = 5'($urandom);
      in_rs2 = 5'($urandom);
      if ($urandom_range(0, 3) == 0) in_imm = 13'($urandom);
      else in_imm = 13'(imm_pool[$urandom_range(0, 10)]);
      step();
    end
    reset = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
